// File: rtl/instruction_queue_if.sv
// instruction_queue_if: in-order issue handshake between the fetch queue and the dispatcher.
interface instruction_queue_if #(
  parameter int IW   = 16,
  parameter int PC_W = 8
);
  logic            issue_ready;
  logic            inst_valid;
  logic [IW-1:0]   inst_out;
  logic [PC_W-1:0] inst_pc;
  modport master (output inst_valid, inst_out, inst_pc, input issue_ready);
  modport slave  (input inst_valid, inst_out, inst_pc, output issue_ready);
endinterface

// File: rtl/instruction_queue.sv
// instruction_queue: program store plus DEPTH-entry fetch FIFO issuing PC-tagged words in order.
// Optional INSTQ_PERF_EN adds a saturating stall_cycles counter.
module instruction_queue #(
  parameter int IW         = 16,
  parameter int DEPTH      = 8,
  parameter int PC_W       = 8,
  parameter int PROG_WORDS = 10,
  parameter logic [IW*PROG_WORDS-1:0] PROG_IMAGE = {
    16'h3204, 16'h3306, 16'h1313, 16'h2504, 16'h3104,
    16'h1142, 16'h0132, 16'h2306, 16'h1531, 16'h0312},
  localparam int CW = $clog2(DEPTH+1),
  localparam int AW = $clog2(DEPTH)
) (
  input  logic            clock,
  input  logic            reset_n,
  instruction_queue_if.master iq,
  input  logic            flush,
  input  logic [PC_W-1:0] flush_pc,
  output logic [CW-1:0]   count,
  output logic            empty,
  output logic            full,
  output logic            halted
`ifdef INSTQ_PERF_EN
  ,
  output logic [15:0]     stall_cycles
`endif
);
  logic [IW-1:0]      prog [2**PC_W];
  logic [IW+PC_W-1:0] mem  [DEPTH];
  logic [AW-1:0]      head, tail;
  logic [PC_W-1:0]    fetch_pc;
  logic               fetch_done, push, pop;
  // Program image is a constant table; addresses past the program read as zero and are never fetched.
  for (genvar g = 0; g < 2**PC_W; g++) begin : g_prog
    if (g < PROG_WORDS) begin : g_w
      assign prog[g] = PROG_IMAGE[g*IW +: IW];
    end else begin : g_z
      assign prog[g] = '0;
    end
  end
  assign empty          = count == '0;
  assign full           = count == CW'(DEPTH);
  assign halted         = fetch_done && empty;
  assign iq.inst_valid  = !empty;
  assign {iq.inst_out, iq.inst_pc} = mem[head];
  assign pop  = iq.inst_valid && iq.issue_ready;
  assign push = !fetch_done && (!full || pop);
  always_ff @(posedge clock)
    if (push && !flush) mem[tail] <= {prog[fetch_pc], fetch_pc};
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      fetch_pc   <= '0;
      fetch_done <= PROG_WORDS == 0;
    end else if (flush) begin
      head       <= '0;
      tail       <= '0;
      count      <= '0;
      fetch_pc   <= flush_pc;
      fetch_done <= 32'(flush_pc) >= PROG_WORDS;
    end else begin
      if (push) begin
        tail       <= tail + AW'(1);
        fetch_pc   <= fetch_pc + PC_W'(1);
        fetch_done <= fetch_pc == PC_W'(PROG_WORDS-1);
      end
      if (pop) head <= head + AW'(1);
      count <= (push && !pop) ? count + CW'(1) : (pop && !push) ? count - CW'(1) : count;
    end
`ifdef INSTQ_PERF_EN
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) stall_cycles <= '0;
    else if (iq.issue_ready && !iq.inst_valid && !halted && !flush && stall_cycles != 16'hFFFF)
      stall_cycles <= stall_cycles + 16'd1;
`endif
endmodule

// File: tb/tb_instruction_queue.sv
// tb_instruction_queue: directed checks of fill, drain, backpressure, flush, async reset and end of program.
module tb_instruction_queue;
  logic        clock = 0;
  logic        reset_n = 0;
  logic        flush = 0;
  logic [7:0]  flush_pc = 0;
  logic [3:0]  count;
  logic        empty, full, halted;
  int          errors = 0, checks = 0;
  logic [15:0] prog [10] = '{16'h0312, 16'h1531, 16'h2306, 16'h0132, 16'h1142,
                             16'h3104, 16'h2504, 16'h1313, 16'h3306, 16'h3204};
`ifdef INSTQ_PERF_EN
  logic [15:0] stall_cycles;
`endif
  instruction_queue_if #(.IW(16), .PC_W(8)) iq ();
  instruction_queue dut (
    .clock(clock), .reset_n(reset_n), .iq(iq), .flush(flush), .flush_pc(flush_pc),
    .count(count), .empty(empty), .full(full), .halted(halted)
`ifdef INSTQ_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clock);
    #1;
  endtask
  task automatic restart(input logic rdy);
    iq.issue_ready = rdy;
    flush = 0;
    reset_n = 0;
    #3;
    chk("rst_valid", iq.inst_valid, 0);
    chk("rst_empty", empty, 1);
    chk("rst_count", count, 0);
    chk("rst_full", full, 0);
    chk("rst_halted", halted, 0);
    @(negedge clock);
    reset_n = 1;
  endtask
  initial begin
    // 1: free-running issue of the whole program
    restart(1);
`ifdef INSTQ_PERF_EN
    chk("perf_rst", stall_cycles, 0);
`endif
    for (int i = 0; i < 10; i++) begin
      step();
      chk("t1_valid", iq.inst_valid, 1);
      chk("t1_pc", iq.inst_pc, i);
      chk("t1_word", iq.inst_out, prog[i]);
    end
    step();
    chk("t1_end_valid", iq.inst_valid, 0);
    chk("t1_halted", halted, 1);
`ifdef INSTQ_PERF_EN
    chk("perf_start", stall_cycles, 1);
    // 6: one empty cycle after a redirect counts; halted and not-ready cycles do not
    flush = 1; flush_pc = 3;
    step();
    flush = 0;
    step();
    chk("perf_flush", stall_cycles, 2);
    repeat (10) step();
    chk("perf_halt", halted, 1);
    chk("perf_halted", stall_cycles, 2);
    iq.issue_ready = 0;
    flush = 1; flush_pc = 3;
    step();
    flush = 0;
    step();
    chk("perf_notready", stall_cycles, 2);
`endif
    // 2: backpressure fills the queue, then back-to-back drain
    restart(0);
    for (int k = 1; k <= 12; k++) begin
      step();
      chk("t2_count", count, k < 8 ? k : 8);
      chk("t2_full", full, k >= 8);
    end
    chk("t2_head", iq.inst_pc, 0);
    iq.issue_ready = 1;
    for (int i = 0; i < 10; i++) begin
      chk("t2_valid", iq.inst_valid, 1);
      chk("t2_pc", iq.inst_pc, i);
      chk("t2_word", iq.inst_out, prog[i]);
      step();
    end
    chk("t2_empty", empty, 1);
    chk("t2_halted", halted, 1);
    // 3: full queue with one pop still pushes
    restart(0);
    repeat (8) step();
    chk("t3_full0", full, 1);
    iq.issue_ready = 1;
    step();
    iq.issue_ready = 0;
    chk("t3_count", count, 8);
    chk("t3_full", full, 1);
    chk("t3_head", iq.inst_pc, 1);
    // 4: flush and redirect, then redirect past the program end
    restart(0);
    repeat (5) step();
    chk("t4_count5", count, 5);
    flush = 1; flush_pc = 3;
    step();
    flush = 0;
    chk("t4_empty", empty, 1);
    chk("t4_count", count, 0);
    step();
    chk("t4_valid", iq.inst_valid, 1);
    chk("t4_pc", iq.inst_pc, 3);
    chk("t4_word", iq.inst_out, 16'h0132);
    flush = 1; flush_pc = 12;
    step();
    flush = 0;
    chk("t4_halted", halted, 1);
    chk("t4_empty2", empty, 1);
    // 5: asynchronous reset between edges
    restart(0);
    repeat (3) step();
    chk("t5_count3", count, 3);
    #2;
    reset_n = 0;
    #1;
    chk("t5_valid", iq.inst_valid, 0);
    chk("t5_count", count, 0);
    chk("t5_empty", empty, 1);
    @(negedge clock);
    reset_n = 1;
    step();
    chk("t5_restart_pc", iq.inst_pc, 0);
    chk("t5_restart_cnt", count, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
